// File: rtl/stage_ctrl.sv
// stage_ctrl: multi-cycle instruction sequencer.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Owns the
// PC, the imem/dmem request handshakes, the retired-instruction counter and
// the sticky halt-on-fault flags (illegal opcode, memory ack timeout).
module stage_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  output logic [2:0]  stage_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  output logic        wd_q_o,
  output logic [31:0] retire_cnt_o,
  output logic        illegal_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } stage_e;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0110111;

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  stage_e     state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       wait_expired;
  logic       is_store;
  logic       is_load;
  logic       is_alu;
  logic       rd_nonzero;

  // Instruction class, taken from the latched IR (stable DECODE..WB).
  assign is_store   = (ir_o[6:0] == OP_S);
  assign is_load    = (ir_o[6:0] == OP_L);
  assign is_alu     = (ir_o[6:0] == OP_R) || (ir_o[6:0] == OP_I) || (ir_o[6:0] == OP_U);
  assign rd_nonzero = (ir_o[11:7] != 5'd0);

  // One more waiting cycle would reach the limit: give up on the ack.
  assign wait_next    = wait_cnt + 8'd1;
  assign wait_expired = (wait_next == WAIT_LIMIT);

  // Handshake outputs are pure decodes of the state register.
  // NOTE: FETCH is also the reset state, so the fetch request is gated by the
  // reset input itself to keep it low while reset is held.
  assign stage_o    = state;
  assign imem_req_o = reset && (state == S_FETCH);
  assign dmem_req_o = (state == S_MEM);
  assign dmem_we_o  = (state == S_MEM) && is_store;

  // Sequencer: stage transitions, PC/IR/counter updates, fault flags, WB strobe.
  // NOTE: all sequential state uses non-blocking assignments so every branch
  // reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_FETCH;
      pc_o         <= RESET_PC;
      ir_o         <= 32'd0;
      retire_cnt_o <= 32'd0;
      illegal_o    <= 1'b0;
      timeout_o    <= 1'b0;
      wait_cnt     <= 8'd0;
      wd_q_o       <= 1'b0;
    end else begin
      wd_q_o <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_ack_i) begin
            ir_o     <= imem_data_i;
            wait_cnt <= 8'd0;
            state    <= S_DECODE;
          end else if (wait_expired) begin
            timeout_o <= 1'b1;
            wait_cnt  <= 8'd0;
            state     <= S_HALT;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        S_DECODE: begin
          if (is_alu || is_store || is_load) begin
            state <= S_EXEC;
          end else begin
            illegal_o <= 1'b1;
            state     <= S_HALT;
          end
        end
        S_EXEC: begin
          if (is_store || is_load) begin
            state <= S_MEM;
          end else begin
            wd_q_o <= rd_nonzero;
            state  <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack_i) begin
            wd_q_o   <= is_load && rd_nonzero;
            wait_cnt <= 8'd0;
            state    <= S_WB;
          end else if (wait_expired) begin
            timeout_o <= 1'b1;
            wait_cnt  <= 8'd0;
            state     <= S_HALT;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        S_WB: begin
          pc_o         <= pc_o + 32'd4;
          retire_cnt_o <= retire_cnt_o + 32'd1;
          state        <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ctrl.sv
// tb_stage_ctrl: directed plus randomized checks of stage_ctrl against an
// instruction-level reference model (expected stage trace per instruction).
module tb_stage_ctrl;

  localparam int          TO       = 4;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [2:0]  ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3,
                          ST_W = 3'd4, ST_H = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'd0;
  logic [31:0] pc_o;
  logic [31:0] ir_o;
  logic [2:0]  stage_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ack_i = 1'b0;
  logic        wd_q_o;
  logic [31:0] retire_cnt_o;
  logic        illegal_o;
  logic        timeout_o;

  stage_ctrl #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req_o   (imem_req_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .pc_o         (pc_o),
    .ir_o         (ir_o),
    .stage_o      (stage_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_ack_i   (dmem_ack_i),
    .wd_q_o       (wd_q_o),
    .retire_cnt_o (retire_cnt_o),
    .illegal_o    (illegal_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ncyc  = 0;

  // Architectural model state.
  logic [31:0] m_pc  = RST_PC;
  logic [31:0] m_ir  = 32'd0;
  logic [31:0] m_ret = 32'd0;
  logic        m_ill = 1'b0;
  logic        m_to  = 1'b0;

  logic [6:0] ops [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // 0 = illegal, 1 = R/I/U, 2 = store, 3 = load
  function automatic int cls(input logic [31:0] w);
    case (w[6:0])
      7'b0110011, 7'b0010011, 7'b0110111: return 1;
      7'b0100011:                         return 2;
      7'b0000011:                         return 3;
      default:                            return 0;
    endcase
  endfunction

  // One clock: check outputs at the falling edge against the expected stage,
  // then drive inputs for the next rising edge.
  task automatic cyc(input logic [2:0] es, input logic ai, input logic [31:0] data, input logic ad);
    int c;
    @(negedge clk);
    c = cls(m_ir);
    check("stage", 32'(stage_o), 32'(es));
    check("imem_req", 32'(imem_req_o), 32'(es == ST_F));
    check("dmem_req", 32'(dmem_req_o), 32'(es == ST_M));
    if (es == ST_M) check("dmem_we", 32'(dmem_we_o), 32'(c == 2));
    check("wd_q", 32'(wd_q_o), 32'((es == ST_W) && (c == 1 || c == 3) && (m_ir[11:7] != 5'd0)));
    check("pc", pc_o, m_pc);
    check("ir", ir_o, m_ir);
    check("retire", retire_cnt_o, m_ret);
    check("illegal", 32'(illegal_o), 32'(m_ill));
    check("timeout", 32'(timeout_o), 32'(m_to));
    imem_ack_i  = ai;
    imem_data_i = data;
    dmem_ack_i  = ad;
    ncyc++;
    @(posedge clk);
  endtask

  // One instruction: wf/wm are wait cycles before the imem/dmem ack.
  // Acks for the non-active port are randomized to prove they are ignored.
  task automatic run_instr(input logic [31:0] w, input int wf, input int wm, output bit halted);
    int c;
    halted = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == wf) begin
        cyc(ST_F, 1'b1, w, rb());
        m_ir = w;
        break;
      end
      cyc(ST_F, 1'b0, $urandom, rb());
      if (i + 1 == TO) begin
        m_to = 1'b1; halted = 1'b1; return;
      end
    end
    cyc(ST_D, rb(), $urandom, rb());
    c = cls(m_ir);
    if (c == 0) begin
      m_ill = 1'b1; halted = 1'b1; return;
    end
    cyc(ST_E, rb(), $urandom, rb());
    if (c >= 2) begin
      for (int i = 0; i < 64; i++) begin
        if (i == wm) begin
          cyc(ST_M, rb(), $urandom, 1'b1);
          break;
        end
        cyc(ST_M, rb(), $urandom, 1'b0);
        if (i + 1 == TO) begin
          m_to = 1'b1; halted = 1'b1; return;
        end
      end
    end
    cyc(ST_W, rb(), $urandom, rb());
    m_pc  = m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(ST_H, rb(), $urandom, rb());
  endtask

  // Called just after a rising edge: assert reset mid-cycle, check the reset
  // state, hold for one cycle and release away from any clock edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    m_pc = RST_PC; m_ir = 32'd0; m_ret = 32'd0; m_ill = 1'b0; m_to = 1'b0;
    check("rst_stage", 32'(stage_o), 32'(ST_F));
    check("rst_imem_req", 32'(imem_req_o), 32'd0);
    check("rst_dmem_req", 32'(dmem_req_o), 32'd0);
    check("rst_dmem_we", 32'(dmem_we_o), 32'd0);
    check("rst_wd_q", 32'(wd_q_o), 32'd0);
    check("rst_pc", pc_o, RST_PC);
    check("rst_ir", ir_o, 32'd0);
    check("rst_retire", retire_cnt_o, 32'd0);
    check("rst_flags", 32'({illegal_o, timeout_o}), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    int start;
    logic [31:0] w;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0100011;
    ops[3] = 7'b0000011; ops[4] = 7'b0110111;

    // Power-on reset
    #3;
    check("por_stage", 32'(stage_o), 32'(ST_F));
    check("por_imem_req", 32'(imem_req_o), 32'd0);
    check("por_pc", pc_o, RST_PC);
    check("por_retire", retire_cnt_o, 32'd0);
    #9 reset = 1'b1;

    // addi x1,x0,5 then nop: 4 cycles each, strobe only for the addi
    start = ncyc;
    run_instr(32'h0050_0093, 0, 0, h);
    check("addi_cycles", 32'(ncyc - start), 32'd4);
    check("addi_halt", 32'(h), 32'd0);
    start = ncyc;
    run_instr(32'h0000_0013, 0, 0, h);
    check("nop_cycles", 32'(ncyc - start), 32'd4);

    // lw x2 with dmem ack after 3 wait cycles: 8 cycles total
    start = ncyc;
    run_instr(32'h0000_A103, 0, 3, h);
    check("lw_cycles", 32'(ncyc - start), 32'd8);

    // sw: store, no strobe, PC still advances
    start = ncyc;
    run_instr(32'h0020_A023, 0, 0, h);
    check("sw_cycles", 32'(ncyc - start), 32'd5);

    // Randomized legal instruction stream with random wait states
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
      run_instr(w, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), h);
      if (h) break;
    end
    check("random_no_halt", 32'(h), 32'd0);

    // Illegal opcode: DECODE then HALT, everything frozen
    run_instr(32'hFFFF_FFFF, 1, 0, h);
    check("illegal_halt", 32'(h), 32'd1);
    halt_cycles(6);

    // Fetch timeout: 4 waiting cycles then HALT, then one-cycle reset
    do_reset();
    run_instr(32'h0050_0093, 0, 0, h);
    run_instr(32'h0000_0013, 100, 0, h);
    check("timeout_halt", 32'(h), 32'd1);
    halt_cycles(4);
    do_reset();

    // Data-side timeout from MEM
    run_instr(32'h0000_A103, 0, 100, h);
    check("mem_timeout_halt", 32'(h), 32'd1);
    halt_cycles(3);
    do_reset();

    // Async reset in the middle of a MEM wait, with a dmem ack pending
    run_instr(32'h0050_0093, 0, 0, h);
    cyc(ST_F, 1'b1, 32'h0020_A023, 1'b0);
    m_ir = 32'h0020_A023;
    cyc(ST_D, 1'b0, 32'd0, 1'b0);
    cyc(ST_E, 1'b0, 32'd0, 1'b0);
    cyc(ST_M, 1'b0, 32'd0, 1'b0);
    #1;
    check("pre_rst_dmem_req", 32'(dmem_req_o), 32'd1);
    dmem_ack_i = 1'b1;
    do_reset();
    cyc(ST_F, 1'b0, 32'd0, 1'b1);
    cyc(ST_F, 1'b0, 32'd0, 1'b1);
    run_instr(32'h0000_A103, 0, 1, h);
    run_instr(32'h0050_0093, 2, 0, h);
    check("post_rst_run", 32'(h), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_ctrl.md
Name: stage_ctrl

Overview:
Multi-cycle sequencer for the core datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the decode stage's stage select, instruction register and register-file write strobe. It also owns the PC, the instruction/data memory request handshakes, a retired-instruction counter, and halt-on-fault detection (illegal opcode, memory timeout).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 255, max wait cycles for imem/dmem ack before fault (1..255)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
imem_req_o  output  1  instruction fetch request, held high in FETCH
imem_ack_i  input  1  fetch data valid this cycle
imem_data_i  input  32  fetched instruction word
pc_o  output  32  current instruction address
ir_o  output  32  latched instruction register, to decode ir_i
stage_o  output  3  current stage, to decode stage_i
dmem_req_o  output  1  data memory request, held high in MEM
dmem_we_o  output  1  1 = store (S type), 0 = load; valid while dmem_req_o
dmem_ack_i  input  1  data access complete this cycle
wd_q_o  output  1  register-file write strobe, one-cycle pulse in WB
retire_cnt_o  output  32  instructions retired
illegal_o  output  1  sticky: illegal opcode seen
timeout_o  output  1  sticky: memory ack timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, pc_o=RESET_PC, ir_o=0, retire_cnt_o=0, illegal_o=0, timeout_o=0, wait counter=0.
  - imem_req_o, dmem_req_o, dmem_we_o and wd_q_o drop to 0 immediately, mid-transaction included.
  - In-flight acks after reset release are ignored unless a request is active.
- State encoding on stage_o: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Encodings 5 and 6 are unused; if reached, the next state is HALT.
- FETCH:
  - imem_req_o=1.
  - On imem_ack_i: ir_o<=imem_data_i, go to DECODE.
  - Otherwise wait counter++. When the counter reaches MEM_TIMEOUT with no ack: timeout_o<=1, go to HALT.
  - The wait counter clears on every state entry.
- DECODE (1 cycle): classify ir_o[6:0].
  - R=7'b0110011, I=7'b0010011, S=7'b0100011, L=7'b0000011, U=7'b0110111.
  - Any other opcode: illegal_o<=1, go to HALT. Otherwise go to EXEC.
- EXEC (1 cycle): S or L goes to MEM; R, I and U go to WB.
- MEM:
  - dmem_req_o=1; dmem_we_o=1 for S, 0 for L.
  - On dmem_ack_i go to WB.
  - Timeout rule is identical to FETCH.
- WB (1 cycle):
  - wd_q_o=1 only for R, I, L or U with ir_o[11:7]!=0. S and rd=x0 give no strobe.
  - pc_o<=pc_o+4, wrapping modulo 2^32.
  - retire_cnt_o++, wrapping modulo 2^32.
  - Go to FETCH.
- HALT: all requests and strobes 0; pc_o, ir_o and counters frozen. Exit only via reset.
- ir_o changes only on a FETCH ack, so it is stable from DECODE through WB.
- Latency with zero-wait memories (ack in the first request cycle):
  - R/I/U: 4 cycles per instruction.
  - S/L: 5 cycles per instruction.
  - Each memory wait cycle adds 1 cycle.
- wd_q_o is registered, so it is glitch-free and high for exactly one cycle per qualifying instruction.
- Acks arriving when the matching request is low are ignored.

Test Plan:
- Reset release, imem acks immediately with 32'h00500093 (addi x1,x0,5), then acks 32'h00000013 forever:
  - Expected: stage_o 0,1,2,4,0 repeating; wd_q_o pulses in cycle 4 only for the first instruction.
  - Expected: pc_o goes 0 to 4, retire_cnt_o=1 after the first WB.
- Load 32'h0000A103 (lw x2), with dmem_ack_i delayed 3 cycles:
  - Expected: MEM lasts 4 cycles with dmem_we_o=0; total 8 cycles; wd_q_o pulses once.
- Store 32'h0020A023 (sw):
  - Expected: dmem_we_o=1 in MEM; WB has wd_q_o=0; pc still advances by 4.
- Fetch returns 32'hFFFFFFFF:
  - Expected: DECODE then HALT; illegal_o=1; stage_o=7.
  - Expected: further imem_ack_i has no effect and pc_o is frozen.
- MEM_TIMEOUT=4, imem never acks:
  - Expected: after 4 waiting cycles timeout_o=1 and state is HALT.
  - Then reset=0 for one cycle: all flags clear and pc_o=RESET_PC.
- Assert reset=0 asynchronously mid-MEM, between clock edges:
  - Expected: dmem_req_o falls the same instant.
  - Expected: after release, the state is FETCH and a pending dmem_ack_i is ignored.
